vec_regfile_arbiter: RTL and testbench
======================================

Name: vec_regfile_arbiter

Overview:
Shares the single-port vector register file (one en/rw/addr/data port, 32 x 64-bit) among several requesters, e.g. operand fetch A, operand fetch B and writeback.
- Grants at most one access per cycle using round-robin arbitration.
- Drives the register-file port from registers.
- Routes each read result back to the requester that issued it, using an in-flight tag pipeline.
- Sits between the vector pipeline stages and vec_regfile.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_W, 64, register data width
ADDR_W, 5, register address width
RD_LAT, 1, cycles from rf_en (rw=0) sampled to valid rf_data_out (1..4)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester access request
req_ready  output  NUM_REQ  one-hot grant; handshake when valid&ready
req_rw  input  NUM_REQ  1=write, 0=read
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  packed write data
rsp_valid  output  NUM_REQ  one-cycle pulse: read data for requester i
rsp_data  output  DATA_W  read data, valid when any rsp_valid bit is set
rf_en  output  1  register-file enable
rf_rw  output  1  register-file direction, 1=write
rf_addr  output  ADDR_W  register-file address
rf_data_in  output  DATA_W  register-file write data
rf_data_out  input  DATA_W  register-file read data

Behaviour:
- Reset, synchronous with rst=1 at a clock edge:
  - req_ready is combinational but forced to 0 while rst=1.
  - rf_en, rf_rw, rf_addr, rf_data_in are 0.
  - rsp_valid and rsp_data are 0.
  - RR pointer is 0.
  - Tag pipeline is cleared. Reads in flight at reset never produce rsp_valid.
- Arbitration, combinational:
  - Scan req_valid starting at RR pointer p, ascending with wrap from NUM_REQ-1 to 0.
  - The first set bit gets req_ready; all others get 0.
  - No valid request means req_ready=0.
  - req_ready does not depend on rsp or rf state; the port accepts one access every cycle.
- Pointer update: on a grant to index g, p <= (g+1) mod NUM_REQ. With no grant, p holds.
- Issue, grant at cycle T:
  - At T+1, registered outputs rf_en=1, rf_rw=req_rw[g], rf_addr=req_addr[g].
  - rf_data_in=req_wdata[g] for writes. For reads, rf_data_in holds its previous value.
  - No grant at T means rf_en=0 at T+1, with rf_rw/rf_addr holding their last values.
- Read return:
  - Tag pipeline of depth RD_LAT+1 carries {read_valid, g}.
  - For a read granted at T, the block samples rf_data_out at the edge ending cycle T+1+RD_LAT.
  - rsp_valid[g]=1 and rsp_data=that value during cycle T+2+RD_LAT, for exactly one cycle.
  - rsp_data holds its last value when no response is pending.
- Throughput and ordering:
  - Back-to-back grants are allowed, one per cycle.
  - Responses return in issue order at one per cycle.
  - At most one rsp_valid bit is set per cycle.
- Hazards:
  - Accesses execute in grant order at the port.
  - A read granted in the cycle after a write to the same address returns the new data, provided vec_regfile writes on the rf_en edge.
  - There is no forwarding inside this block.
- Requester protocol:
  - A requester holds valid/rw/addr/wdata stable until granted.
  - Deasserting valid before grant withdraws the request without side effects.
- Writes produce no response.

Test Plan:
1. Single write then read. Requester 0 writes addr 5, data 0xABCDEF0123456789, then reads addr 5. Required: rf_en/rw=1/addr=5 one cycle after the write grant; rsp_valid[0] with rsp_data=0xABCDEF0123456789 exactly RD_LAT+2 cycles after the read grant; no rsp for the write.
2. Round robin. All 3 requesters hold reads of addrs 1, 2, 3 (preloaded 0x11, 0x22, 0x33) continuously. Required: grants 0,1,2,0,... on consecutive cycles; rsp_valid order 0,1,2 with data 0x11, 0x22, 0x33; never two rsp_valid bits in one cycle.
3. Pointer wrap and skip. p=2 with only requesters 0 and 1 valid. Required: grant 0, then 1.
4. Write-then-read same address from different requesters. Req 2 writes addr 7 = 0x55, then req 1 reads addr 7 on the next grant. Required: rsp_valid[1] with rsp_data=0x55.
5. Reset mid-flight. Assert rst the cycle after a read grant. Required: rf_en=0, req_ready=0, no rsp_valid at any later cycle, p=0; the first request after reset is granted to index 0 when all are valid.
6. RD_LAT=3 build. Repeat scenario 2. Required: each rsp_valid occurs 5 cycles after its grant; order preserved.

Source files
------------

// File: rtl/vec_regfile_arbiter_if.sv
// Requester-side bundle of the vector register-file arbiter: access requests
// with a one-hot grant, plus the read-response return path.
interface vec_regfile_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/vec_regfile_arbiter.sv
// Round-robin arbiter sharing one single-port vector register file among
// NUM_REQ requesters; read data is steered back via an in-flight tag pipe.
module vec_regfile_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  vec_regfile_arbiter_if.slave bus,
  output logic                rf_en,
  output logic                rf_rw,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data_in,
  input  logic [DATA_W-1:0]   rf_data_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned TAG_N = RD_LAT + 1;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [SUM_W-1:0]   cand;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  logic               tag_vld [TAG_N];
  logic [IDX_W-1:0]   tag_idx [TAG_N];

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;

  always_comb begin : unpack_req
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // First valid requester at or after ptr, wrapping; nothing is granted in reset.
  always_comb begin : rr_arb
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = SUM_W'(ptr) + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!gnt_any && bus.req_valid[IDX_W'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
    if (rst) begin
      gnt_any = 1'b0;
    end
    gnt_vec = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  assign bus.req_ready = gnt_vec;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // Port issue, tag pipeline and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      rf_en       <= 1'b0;
      rf_rw       <= 1'b0;
      rf_addr     <= '0;
      rf_data_in  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int unsigned k = 0; k < TAG_N; k++) begin
        tag_vld[k] <= 1'b0;
        tag_idx[k] <= '0;
      end
    end else begin
      rf_en <= gnt_any;
      if (gnt_any) begin
        ptr     <= ptr_nxt;
        rf_rw   <= bus.req_rw[gnt_idx];
        rf_addr <= addr_arr[gnt_idx];
        if (bus.req_rw[gnt_idx]) begin
          rf_data_in <= wdata_arr[gnt_idx];
        end
      end

      // Stage k is aligned with cycle issue+1+k; stage RD_LAT meets valid read data.
      tag_vld[0] <= gnt_any & ~bus.req_rw[gnt_idx];
      tag_idx[0] <= gnt_idx;
      for (int unsigned k = 1; k < TAG_N; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end

      rsp_valid_q <= tag_vld[RD_LAT] ? (NUM_REQ'(1) << tag_idx[RD_LAT]) : '0;
      if (tag_vld[RD_LAT]) begin
        rsp_data_q <= rf_data_out;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge clk) $onehot0(gnt_vec));
  a_rsp_onehot:   assert property (@(posedge clk) $onehot0(rsp_valid_q));

endmodule

// File: tb/tb_vec_regfile_arbiter.sv
// Directed bench for vec_regfile_arbiter with a behavioural single-port
// register file returning read data RD_LAT cycles after the enable edge.
module tb_vec_regfile_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int RD_LAT  = 1;

  localparam logic [63:0] D1 = 64'hABCDEF0123456789;

  logic              clk = 1'b0;
  logic              rst;
  logic              rf_en;
  logic              rf_rw;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] rf_data_out;

  int n_checks    = 0;
  int n_errors    = 0;
  int onehot_viol = 0;

  vec_regfile_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vec_regfile_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rf_en      (rf_en),
    .rf_rw      (rf_rw),
    .rf_addr    (rf_addr),
    .rf_data_in (rf_data_in),
    .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // Register file model, preloaded while reset is held.
  logic [DATA_W-1:0] mem     [32];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (rst) begin
      mem[1] <= 64'h11;
      mem[2] <= 64'h22;
      mem[3] <= 64'h33;
    end else if (rf_en && rf_rw) begin
      mem[rf_addr] <= rf_data_in;
    end
    if (rf_en && !rf_rw) rd_pipe[0] <= mem[rf_addr];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign rf_data_out = rd_pipe[RD_LAT-1];

  always @(negedge clk) begin
    if (!rst && $countones(bus.rsp_valid) > 1) onehot_viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [63:0] ev, input logic [63:0] ed);
    chk({tag, "_valid"}, 64'(bus.rsp_valid), ev);
    if (ev != 64'd0) chk({tag, "_data"}, 64'(bus.rsp_data), ed);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic rw,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid[i]                  = v;
    bus.req_rw[i]                     = rw;
    bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 5'(i + 1), 64'd0);
    step();
    step();
    #1;
    chk("rst_ready",      64'(bus.req_ready), 64'd0);
    chk("rst_rf_en",      64'(rf_en),         64'd0);
    chk("rst_rf_addr",    64'(rf_addr),       64'd0);
    chk("rst_rf_data_in", rf_data_in,         64'd0);
    chk("rst_rsp_valid",  64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data",   bus.rsp_data,       64'd0);
    clear_all();
    rst = 1'b0;
    step();

    // Single write then read by requester 0.
    set_req(0, 1'b1, 1'b1, 5'd5, D1);
    #1;
    chk("s1_wr_gnt", 64'(bus.req_ready), 64'b001);
    step();
    chk("s1_wr_en",   64'(rf_en),   64'd1);
    chk("s1_wr_rw",   64'(rf_rw),   64'd1);
    chk("s1_wr_addr", 64'(rf_addr), 64'd5);
    chk("s1_wr_data", rf_data_in,   D1);
    set_req(0, 1'b1, 1'b0, 5'd5, 64'd0);
    #1;
    chk("s1_rd_gnt", 64'(bus.req_ready), 64'b001);
    for (int k = 1; k <= RD_LAT + 3; k++) begin
      step();
      if (k == 1) begin
        clear_all();
        chk("s1_rd_en",        64'(rf_en),   64'd1);
        chk("s1_rd_rw",        64'(rf_rw),   64'd0);
        chk("s1_rd_addr",      64'(rf_addr), 64'd5);
        chk("s1_rd_data_hold", rf_data_in,   D1);
      end
      if (k == 2) chk("s1_idle_en", 64'(rf_en), 64'd0);
      chk_rsp("s1_rsp", (k == RD_LAT + 2) ? 64'b001 : 64'd0, D1);
    end
    chk("s1_rsp_hold", bus.rsp_data, D1);

    // Write by requester 2, then read of the same address by requester 1.
    set_req(2, 1'b1, 1'b1, 5'd7, 64'h55);
    #1;
    chk("s4_wr_gnt", 64'(bus.req_ready), 64'b100);
    step();
    clear_all();
    set_req(1, 1'b1, 1'b0, 5'd7, 64'd0);
    #1;
    chk("s4_rd_gnt",  64'(bus.req_ready), 64'b010);
    chk("s4_wr_rw",   64'(rf_rw),   64'd1);
    chk("s4_wr_addr", 64'(rf_addr), 64'd7);
    chk("s4_wr_data", rf_data_in,   64'h55);
    for (int k = 1; k <= RD_LAT + 3; k++) begin
      step();
      if (k == 1) begin
        clear_all();
        chk("s4_rd_rw", 64'(rf_rw), 64'd0);
      end
      chk_rsp("s4_rsp", (k == RD_LAT + 2) ? 64'b010 : 64'd0, 64'h55);
    end

    // Pointer sits at 2 with only requesters 0 and 1 asking: wrap to 0, then 1.
    set_req(0, 1'b1, 1'b0, 5'd1, 64'd0);
    set_req(1, 1'b1, 1'b0, 5'd2, 64'd0);
    #1;
    chk("s3_gnt0", 64'(bus.req_ready), 64'b001);
    step();
    set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);
    #1;
    chk("s3_gnt1", 64'(bus.req_ready), 64'b010);
    for (int k = 2; k <= RD_LAT + 4; k++) begin
      step();
      if (k == 2) clear_all();
      if (k == RD_LAT + 2)      chk_rsp("s3_rsp", 64'b001, 64'h11);
      else if (k == RD_LAT + 3) chk_rsp("s3_rsp", 64'b010, 64'h22);
      else                      chk_rsp("s3_rsp", 64'd0,   64'd0);
    end

    // Reset the cycle after a read grant; pointer sits at 2 beforehand.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 5'(i + 1), 64'd0);
    #1;
    chk("s5_gnt", 64'(bus.req_ready), 64'b100);
    step();
    rst = 1'b1;
    #1;
    chk("s5_rst_ready",  64'(bus.req_ready), 64'd0);
    chk("s5_rf_en_pre",  64'(rf_en),         64'd1);
    step();
    chk("s5_rf_en",      64'(rf_en),         64'd0);
    chk("s5_rsp_valid",  64'(bus.rsp_valid), 64'd0);
    chk("s5_rsp_data",   bus.rsp_data,       64'd0);
    chk("s5_ready",      64'(bus.req_ready), 64'd0);
    step();
    rst = 1'b0;

    // All three requesters read continuously right after reset.
    for (int c = 0; c <= RD_LAT + 8; c++) begin
      int k;
      if (c > 0) step();
      if (c == 6) clear_all();
      #1;
      if (c < 6) chk("s2_gnt", 64'(bus.req_ready), 64'(1 << (c % 3)));
      if (c >= 1 && c <= 6) chk("s2_rf_addr", 64'(rf_addr), 64'((c - 1) % 3 + 1));
      k = c - 2 - RD_LAT;
      if (k >= 0 && k < 6) chk_rsp("s2_rsp", 64'(1 << (k % 3)), 64'(32'h11 * (k % 3 + 1)));
      else                 chk_rsp("s2_rsp", 64'd0, 64'd0);
    end

    chk("rsp_onehot", 64'(onehot_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
